vpu_pixel_pipe: RTL

VPU_PIXEL_PIPE -- requirements
Module: vpu_pixel_pipe

---
 rtl/vpu_pkg.sv | 29 ++
 rtl/vpu_lane_op.sv | 40 ++++
 rtl/vpu_pixel_pipe.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_pkg
//  Description : Shared definitions for the VPU pixel pipeline: the processing
//                mode encoding and the per-lane saturation helper.
//  Revision    : 1.0  initial release
// ============================================================================
package vpu_pkg;

   // Processing modes, encoded exactly as presented on cfg_mode.
   typedef enum logic [1:0] {
      MODE_BYPASS = 2'b00,
      MODE_INVERT = 2'b01,
      MODE_OFFSET = 2'b10,
      MODE_THRESH = 2'b11
   } vpu_mode_e;

   // Saturate a signed lane sum into the range 0..max_val.
   function automatic int lane_clamp(input int sum, input int max_val);
      if (sum < 0) begin
         return 0;
      end else if (sum > max_val) begin
         return max_val;
      end
      return sum;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_lane_op.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_lane_op
//  Description : Combinational single-lane pixel operation.
//  Ports       : i_pix    - input pixel
//                i_mode   - processing mode (bypass/invert/offset/threshold)
//                i_offset - signed offset, one bit wider than a pixel
//                i_thr    - threshold level
//                o_pix    - processed pixel
//  Revision    : 1.0  initial release
// ============================================================================
module vpu_lane_op
   import vpu_pkg::*;
#(
   parameter int PIX_W = 8
) (
   input  logic [PIX_W-1:0]        i_pix,
   input  vpu_mode_e               i_mode,
   input  logic signed [PIX_W:0]   i_offset,
   input  logic [PIX_W-1:0]        i_thr,
   output logic [PIX_W-1:0]        o_pix
);

   // Two extra bits hold both the carry above full scale and the sign.
   logic signed [PIX_W+1:0] w_sum;

   assign w_sum = $signed({2'b00, i_pix}) + (PIX_W+2)'(i_offset);

   always_comb begin
      o_pix = i_pix;
      unique case (i_mode)
         MODE_BYPASS: o_pix = i_pix;
         MODE_INVERT: o_pix = ~i_pix;
         MODE_OFFSET: o_pix = PIX_W'(lane_clamp(int'(w_sum), (1 << PIX_W) - 1));
         MODE_THRESH: o_pix = (i_pix >= i_thr) ? '1 : '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/vpu_pixel_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_pixel_pipe
//  Description : Two-stage streaming pixel processor with line/frame tagging.
//                Stage 1 captures the input word with its position tags;
//                stage 2 holds the processed word presented at the output.
//  Ports       : clk, reset_n (synchronous, active-low)
//                video_data_in/in_valid/in_sof/in_ready  - input stream
//                video_data_out/out_valid/out_ready/out_eol/out_eof - output
//                cfg_mode/cfg_offset/cfg_thr - per-frame configuration
//                video_processed/frame_done/sync_err/frame_cnt - status
//  Revision    : 1.0  initial release
// ============================================================================
module vpu_pixel_pipe
   import vpu_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int PIX_W          = 8,
   parameter int WORDS_PER_LINE = 160,
   parameter int LINES          = 480
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_W-1:0]     video_data_in,
   input  logic                  in_valid,
   input  logic                  in_sof,
   output logic                  in_ready,
   output logic [DATA_W-1:0]     video_data_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_eol,
   output logic                  out_eof,
   input  logic [1:0]            cfg_mode,
   input  logic signed [PIX_W:0] cfg_offset,
   input  logic [PIX_W-1:0]      cfg_thr,
   output logic                  video_processed,
   output logic                  frame_done,
   output logic                  sync_err,
   output logic [15:0]           frame_cnt
);

   localparam int LANES = DATA_W / PIX_W;
   localparam int COL_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam int ROW_W = (LINES > 1) ? $clog2(LINES) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS_PER_LINE - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINES - 1);

   logic [DATA_W-1:0]     data1_q, data1_d, data2_q, data2_d;
   logic                  valid1_q, valid1_d, valid2_q, valid2_d;
   logic                  eol1_q, eol1_d, eof1_q, eof1_d;
   logic                  eol2_q, eol2_d, eof2_q, eof2_d;
   logic [COL_W-1:0]      col_q, col_d;
   logic [ROW_W-1:0]      row_q, row_d;
   vpu_mode_e             cfg_mode_q, cfg_mode_d;
   logic signed [PIX_W:0] cfg_offset_q, cfg_offset_d;
   logic [PIX_W-1:0]      cfg_thr_q, cfg_thr_d;
   logic                  sync_err_q, sync_err_d;
   logic                  frame_done_q, frame_done_d;
   logic                  video_processed_q, video_processed_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;

   logic                  w_s2_free, w_s2_load, w_accept;
   logic [COL_W-1:0]      w_eff_col;
   logic [ROW_W-1:0]      w_eff_row;
   logic                  w_col_last, w_row_last, w_frame_start, w_eof_xfer;
   logic [DATA_W-1:0]     w_lane_res;

   // Stage 1 may accept whenever it is empty or about to move into stage 2.
   assign in_ready = reset_n & (w_s2_free | ~valid1_q);

   // The stage-1 word is always processed with the cfg of its own frame:
   // a frame-start word can only enter stage 1 on the same edge that the
   // previous word leaves it, so cfg_*_q never runs ahead of stage 1.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      vpu_lane_op #(.PIX_W(PIX_W)) u_lane_op (
         .i_pix    (data1_q[g*PIX_W +: PIX_W]),
         .i_mode   (cfg_mode_q),
         .i_offset (cfg_offset_q),
         .i_thr    (cfg_thr_q),
         .o_pix    (w_lane_res[g*PIX_W +: PIX_W])
      );
   end

   always_comb begin
      w_s2_free     = ~valid2_q | out_ready;
      w_s2_load     = valid1_q & w_s2_free;
      w_accept      = in_valid & in_ready;
      // A start-of-frame tag forces the word to position 0,0.
      w_eff_col     = in_sof ? '0 : col_q;
      w_eff_row     = in_sof ? '0 : row_q;
      w_col_last    = (w_eff_col == COL_LAST);
      w_row_last    = (w_eff_row == ROW_LAST);
      w_frame_start = (w_eff_col == '0) && (w_eff_row == '0);
      w_eof_xfer    = valid2_q & out_ready & eof2_q;

      data1_d           = data1_q;
      valid1_d          = valid1_q;
      eol1_d            = eol1_q;
      eof1_d            = eof1_q;
      data2_d           = data2_q;
      valid2_d          = valid2_q;
      eol2_d            = eol2_q;
      eof2_d            = eof2_q;
      col_d             = col_q;
      row_d             = row_q;
      cfg_mode_d        = cfg_mode_q;
      cfg_offset_d      = cfg_offset_q;
      cfg_thr_d         = cfg_thr_q;
      sync_err_d        = sync_err_q;
      frame_done_d      = w_eof_xfer;
      video_processed_d = video_processed_q | w_eof_xfer;
      frame_cnt_d       = frame_cnt_q + (w_eof_xfer ? 16'd1 : 16'd0);

      // Stage 2: refill from stage 1 whenever the output slot frees up.
      if (w_s2_free) begin
         valid2_d = valid1_q;
      end
      if (w_s2_load) begin
         data2_d  = w_lane_res;
         eol2_d   = eol1_q;
         eof2_d   = eof1_q;
         valid1_d = 1'b0;
      end

      if (w_accept) begin
         data1_d  = video_data_in;
         valid1_d = 1'b1;
         eol1_d   = w_col_last;
         eof1_d   = w_col_last & w_row_last;
         col_d    = w_col_last ? '0 : w_eff_col + COL_W'(1);
         row_d    = w_col_last ? (w_row_last ? '0 : w_eff_row + ROW_W'(1)) : w_eff_row;
         if (w_frame_start) begin
            cfg_mode_d   = vpu_mode_e'(cfg_mode);
            cfg_offset_d = cfg_offset;
            cfg_thr_d    = cfg_thr;
         end
         if (in_sof && ((col_q != '0) || (row_q != '0))) begin
            sync_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data1_q           <= '0;
         valid1_q          <= 1'b0;
         eol1_q            <= 1'b0;
         eof1_q            <= 1'b0;
         data2_q           <= '0;
         valid2_q          <= 1'b0;
         eol2_q            <= 1'b0;
         eof2_q            <= 1'b0;
         col_q             <= '0;
         row_q             <= '0;
         cfg_mode_q        <= MODE_BYPASS;
         cfg_offset_q      <= '0;
         cfg_thr_q         <= '0;
         sync_err_q        <= 1'b0;
         frame_done_q      <= 1'b0;
         video_processed_q <= 1'b0;
         frame_cnt_q       <= '0;
      end else begin
         data1_q           <= data1_d;
         valid1_q          <= valid1_d;
         eol1_q            <= eol1_d;
         eof1_q            <= eof1_d;
         data2_q           <= data2_d;
         valid2_q          <= valid2_d;
         eol2_q            <= eol2_d;
         eof2_q            <= eof2_d;
         col_q             <= col_d;
         row_q             <= row_d;
         cfg_mode_q        <= cfg_mode_d;
         cfg_offset_q      <= cfg_offset_d;
         cfg_thr_q         <= cfg_thr_d;
         sync_err_q        <= sync_err_d;
         frame_done_q      <= frame_done_d;
         video_processed_q <= video_processed_d;
         frame_cnt_q       <= frame_cnt_d;
      end
   end

   assign video_data_out  = data2_q;
   assign out_valid       = valid2_q;
   assign out_eol         = eol2_q;
   assign out_eof         = eof2_q;
   assign sync_err        = sync_err_q;
   assign frame_done      = frame_done_q;
   assign video_processed = video_processed_q;
   assign frame_cnt       = frame_cnt_q;

endmodule
`default_nettype wire
